// File: rtl/port_led_ctrl_if.sv
// -----------------------------------------------------------------------------
// port_led_ctrl_if
// Bundles the hub status inputs and the front-panel LED outputs of
// port_led_ctrl.
//   link         : per-port link status (level)
//   activity     : per-port activity (pulse or level)
//   evt          : hub-wide event strobes (pulse or level); "event" is a
//                  SystemVerilog keyword, hence the shorter name
//   test_mode    : lamp test enable (level)
//   link_act_led : per-port link/activity LED, 1 = lit
//   event_led    : stretched event LEDs, 1 = lit
// master drives the status side, slave is the LED controller.
// -----------------------------------------------------------------------------
interface port_led_ctrl_if #(
   parameter int PORTS  = 4,
   parameter int EVENTS = 2
);
   logic [PORTS-1:0]  link;
   logic [PORTS-1:0]  activity;
   logic [EVENTS-1:0] evt;
   logic              test_mode;
   logic [PORTS-1:0]  link_act_led;
   logic [EVENTS-1:0] event_led;

   modport master (
      output link, activity, evt, test_mode,
      input  link_act_led, event_led
   );

   modport slave (
      input  link, activity, evt, test_mode,
      output link_act_led, event_led
   );
endinterface

// File: rtl/port_led_ctrl.sv
// -----------------------------------------------------------------------------
// port_led_ctrl
// Front-panel LED controller for the hub.
//   - One link/activity LED per port: dark with link down, steady on with link
//     up, blinks off/on while traffic is pending.
//   - Pulse-stretched LEDs for hub-wide events.
//   - Lamp test walking a single lit LED over {event_led, link_act_led}.
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : port_led_ctrl_if.slave (status inputs, LED outputs)
// All LED outputs come straight from flops.
// -----------------------------------------------------------------------------
module port_led_ctrl #(
   parameter int PORTS         = 4,
   parameter int EVENTS        = 2,
   parameter int TICK_DIV      = 1250000,
   parameter int BLINK_TICKS   = 3,
   parameter int STRETCH_TICKS = 6,
   parameter int TEST_TICKS    = 25
) (
   input logic           clk,
   input logic           rst,
   port_led_ctrl_if.slave bus
);

   localparam int PW = $clog2(TICK_DIV);
   localparam int BW = $clog2(BLINK_TICKS + 1);
   localparam int SW = $clog2(STRETCH_TICKS + 1);
   localparam int TW = $clog2(TEST_TICKS + 1);
   localparam int NL = PORTS + EVENTS;
   localparam int IW = $clog2(NL);

   typedef enum logic [1:0] {
      ST_OFF     = 2'd0,
      ST_IDLE    = 2'd1,
      ST_BLK_OFF = 2'd2,
      ST_BLK_ON  = 2'd3
   } port_state_t;

   logic [PW-1:0]     presc_r;
   logic              tick_r;
   logic [PORTS-1:0]  norm_port_s;
   logic [EVENTS-1:0] norm_evt_s;
   logic              test_prev_r;
   logic [IW-1:0]     tidx_r, tidx_s;
   logic [TW-1:0]     tcnt_r, tcnt_s;
   logic [NL-1:0]     walk_s;
   logic [PORTS-1:0]  port_led_r;
   logic [EVENTS-1:0] evt_led_r;

   // Timebase prescaler; tick is registered so the first tick after reset
   // release arrives TICK_DIV cycles later.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_r <= PW'(0);
         tick_r  <= 1'b0;
      end else begin
         tick_r <= (presc_r == PW'(TICK_DIV - 1));
         if (presc_r == PW'(TICK_DIV - 1)) begin
            presc_r <= PW'(0);
         end else begin
            presc_r <= presc_r + PW'(1);
         end
      end
   end

   for (genvar p = 0; p < PORTS; p++) begin : g_port
      port_state_t   state_r, state_s;
      logic [BW-1:0] cnt_r, cnt_s;
      logic          pend_r, pend_s, pend_clr_s;

      // Port state, phase counter and pending-activity flag.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_r <= ST_OFF;
            cnt_r   <= BW'(0);
            pend_r  <= 1'b0;
         end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            pend_r  <= pend_s;
         end
      end

      // Next-state logic; link loss overrides everything.
      always_comb begin
         state_s    = state_r;
         cnt_s      = cnt_r;
         pend_clr_s = 1'b0;
         if (!bus.link[p]) begin
            state_s    = ST_OFF;
            cnt_s      = BW'(0);
            pend_clr_s = 1'b1;
         end else begin
            case (state_r)
               ST_OFF: begin
                  state_s = ST_IDLE;
               end
               ST_IDLE: begin
                  if (pend_r) begin
                     state_s    = ST_BLK_OFF;
                     cnt_s      = BW'(BLINK_TICKS);
                     pend_clr_s = 1'b1;
                  end else begin
                     state_s = ST_IDLE;
                  end
               end
               ST_BLK_OFF: begin
                  if (tick_r) begin
                     if (cnt_r == BW'(1)) begin
                        state_s = ST_BLK_ON;
                        cnt_s   = BW'(BLINK_TICKS);
                     end else begin
                        cnt_s = cnt_r - BW'(1);
                     end
                  end else begin
                     cnt_s = cnt_r;
                  end
               end
               ST_BLK_ON: begin
                  if (tick_r) begin
                     if (cnt_r != BW'(1)) begin
                        cnt_s = cnt_r - BW'(1);
                     end else if (pend_r) begin
                        // traffic arrived during this blink: chain another
                        // blink without restarting the phase in progress
                        state_s    = ST_BLK_OFF;
                        cnt_s      = BW'(BLINK_TICKS);
                        pend_clr_s = 1'b1;
                     end else begin
                        state_s = ST_IDLE;
                        cnt_s   = BW'(0);
                     end
                  end else begin
                     cnt_s = cnt_r;
                  end
               end
               default: begin
                  state_s = ST_OFF;
                  cnt_s   = BW'(0);
               end
            endcase
         end
         // a new set in the same cycle as a clear wins
         pend_s = (bus.link[p] & bus.activity[p]) | (pend_r & ~pend_clr_s);
      end

      assign norm_port_s[p] = (state_r == ST_IDLE) || (state_r == ST_BLK_ON);
   end

   for (genvar e = 0; e < EVENTS; e++) begin : g_evt
      logic [SW-1:0] ecnt_r;

      // Stretch counter: event reloads (wins over a tick), tick decrements.
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            ecnt_r <= SW'(0);
         end else if (bus.evt[e]) begin
            ecnt_r <= SW'(STRETCH_TICKS);
         end else if (tick_r && (ecnt_r != SW'(0))) begin
            ecnt_r <= ecnt_r - SW'(1);
         end else begin
            ecnt_r <= ecnt_r;
         end
      end

      assign norm_evt_s[e] = (ecnt_r != SW'(0));
   end

   // Lamp-test walk index: restart on the rising edge of test_mode, advance
   // every TEST_TICKS ticks while test_mode is held.
   always_comb begin
      tidx_s = tidx_r;
      tcnt_s = tcnt_r;
      if (bus.test_mode && !test_prev_r) begin
         tidx_s = IW'(0);
         tcnt_s = TW'(TEST_TICKS);
      end else if (bus.test_mode && tick_r) begin
         if (tcnt_r <= TW'(1)) begin
            tcnt_s = TW'(TEST_TICKS);
            if (tidx_r == IW'(NL - 1)) begin
               tidx_s = IW'(0);
            end else begin
               tidx_s = tidx_r + IW'(1);
            end
         end else begin
            tcnt_s = tcnt_r - TW'(1);
         end
      end else begin
         tidx_s = tidx_r;
         tcnt_s = tcnt_r;
      end
      walk_s = {{(NL - 1){1'b0}}, 1'b1} << tidx_s;
   end

   // Lamp-test bookkeeping and the registered LED outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         test_prev_r <= 1'b0;
         tidx_r      <= IW'(0);
         tcnt_r      <= TW'(0);
         port_led_r  <= PORTS'(0);
         evt_led_r   <= EVENTS'(0);
      end else begin
         test_prev_r <= bus.test_mode;
         tidx_r      <= tidx_s;
         tcnt_r      <= tcnt_s;
         if (bus.test_mode) begin
            port_led_r <= walk_s[PORTS-1:0];
            evt_led_r  <= walk_s[NL-1:PORTS];
         end else begin
            port_led_r <= norm_port_s;
            evt_led_r  <= norm_evt_s;
         end
      end
   end

   assign bus.link_act_led = port_led_r;
   assign bus.event_led    = evt_led_r;

endmodule

// File: tb/tb_port_led_ctrl.sv
// -----------------------------------------------------------------------------
// tb_port_led_ctrl
// Self-checking bench for port_led_ctrl with small timing parameters.
// A behavioural model (tick arithmetic, per-port lamp mode, stretch timers,
// lamp-test index) predicts both LED vectors every cycle; directed scenarios
// additionally measure phase lengths against the allowed windows.
// -----------------------------------------------------------------------------
module tb_port_led_ctrl;
   localparam int P   = 4;
   localparam int E   = 2;
   localparam int TD  = 4;
   localparam int BT  = 2;
   localparam int STR = 3;
   localparam int TT  = 2;
   localparam int N   = P + E;

   // model lamp modes for a port
   localparam int M_DARK   = 0;
   localparam int M_STEADY = 1;
   localparam int M_GAP    = 2;
   localparam int M_FLASH  = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   port_led_ctrl_if #(.PORTS(P), .EVENTS(E)) bus ();

   port_led_ctrl #(
      .PORTS(P), .EVENTS(E), .TICK_DIV(TD), .BLINK_TICKS(BT),
      .STRETCH_TICKS(STR), .TEST_TICKS(TT)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   int          m_presc;
   bit          m_tick;
   int          m_mode [P];
   int          m_left [P];
   bit          m_pend [P];
   int          m_ev_left [E];
   bit          m_tprev;
   int          m_tidx;
   int          m_tleft;
   logic [P-1:0] exp_port;
   logic [E-1:0] exp_ev;

   task automatic model_reset();
      m_presc = 0;
      m_tick  = 1'b0;
      for (int p = 0; p < P; p++) begin
         m_mode[p] = M_DARK;
         m_left[p] = 0;
         m_pend[p] = 1'b0;
      end
      for (int e = 0; e < E; e++) m_ev_left[e] = 0;
      m_tprev  = 1'b0;
      m_tidx   = 0;
      m_tleft  = 0;
      exp_port = '0;
      exp_ev   = '0;
   endtask

   // advance the model by one clock edge using the inputs currently applied
   task automatic model_edge();
      logic [P-1:0] norm_p;
      logic [E-1:0] norm_e;
      logic [N-1:0] walk;
      for (int p = 0; p < P; p++) norm_p[p] = (m_mode[p] == M_STEADY) || (m_mode[p] == M_FLASH);
      for (int e = 0; e < E; e++) norm_e[e] = (m_ev_left[e] > 0);
      for (int p = 0; p < P; p++) begin
         if (!bus.link[p]) begin
            m_mode[p] = M_DARK;
            m_left[p] = 0;
            m_pend[p] = 1'b0;
         end else begin
            if (m_mode[p] == M_DARK) begin
               m_mode[p] = M_STEADY;
            end else if (m_mode[p] == M_STEADY) begin
               if (m_pend[p]) begin
                  m_mode[p] = M_GAP;
                  m_left[p] = BT;
                  m_pend[p] = 1'b0;
               end
            end else if (m_tick) begin
               m_left[p]--;
               if (m_left[p] == 0) begin
                  if (m_mode[p] == M_GAP) begin
                     m_mode[p] = M_FLASH;
                     m_left[p] = BT;
                  end else if (m_pend[p]) begin
                     m_mode[p] = M_GAP;
                     m_left[p] = BT;
                     m_pend[p] = 1'b0;
                  end else begin
                     m_mode[p] = M_STEADY;
                  end
               end
            end
            if (bus.activity[p]) m_pend[p] = 1'b1;
         end
      end
      for (int e = 0; e < E; e++) begin
         if (bus.evt[e]) m_ev_left[e] = STR;
         else if (m_tick && m_ev_left[e] > 0) m_ev_left[e]--;
      end
      if (bus.test_mode && !m_tprev) begin
         m_tidx  = 0;
         m_tleft = TT;
      end else if (bus.test_mode && m_tick) begin
         m_tleft--;
         if (m_tleft == 0) begin
            m_tidx  = (m_tidx + 1) % N;
            m_tleft = TT;
         end
      end
      m_tprev = bus.test_mode;
      if (bus.test_mode) begin
         walk = '0;
         walk[m_tidx] = 1'b1;
         exp_port = walk[P-1:0];
         exp_ev   = walk[N-1:P];
      end else begin
         exp_port = norm_p;
         exp_ev   = norm_e;
      end
      m_tick  = (m_presc == TD - 1);
      m_presc = (m_presc + 1) % TD;
   endtask

   // apply inputs (called at a negedge), clock once, compare at next negedge
   task automatic cycle(input logic [P-1:0] l, input logic [P-1:0] a,
                        input logic [E-1:0] ev, input logic tm);
      bus.link      = l;
      bus.activity  = a;
      bus.evt       = ev;
      bus.test_mode = tm;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check("port_led", bus.link_act_led, exp_port);
      check("event_led", bus.event_led, exp_ev);
   endtask

   // asynchronous reset away from any clock edge, released at a negedge
   task automatic do_reset();
      #2 rst = 1'b1;
      #1;
      check("async_rst_port", bus.link_act_led, 32'd0);
      check("async_rst_evt", bus.event_led, 32'd0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      int falls, zeros, ones, last, prev_t, runs, run_start, len, b;
      logic [P-1:0] lnk, act;
      logic [E-1:0] ev;
      logic         tm;
      logic [103:0] hist;
      logic [N-1:0] wsmp [80];
      logic [N-1:0] oh;

      rst           = 1'b1;
      bus.link      = '0;
      bus.activity  = '0;
      bus.evt       = '0;
      bus.test_mode = 1'b0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      check("reset_port", bus.link_act_led, 32'd0);
      check("reset_evt", bus.event_led, 32'd0);
      rst = 1'b0;

      // link up on ports 0 and 2: LED follows two cycles later
      cycle(4'b0101, 4'b0000, 2'b00, 1'b0);
      check("link_lat1", bus.link_act_led, 32'h0);
      cycle(4'b0101, 4'b0000, 2'b00, 1'b0);
      check("link_lat2", bus.link_act_led, 32'h5);
      cycle(4'b0001, 4'b0000, 2'b00, 1'b0);
      cycle(4'b0001, 4'b0000, 2'b00, 1'b0);
      check("link_drop2", bus.link_act_led, 32'h1);
      for (int j = 0; j < 3; j++) cycle(4'b0001, 4'b0000, 2'b00, 1'b0);

      // single blink on port 0
      for (int j = 0; j < 40; j++) begin
         cycle(4'b0001, (j == 0) ? 4'b0001 : 4'b0000, 2'b00, 1'b0);
         hist[j] = bus.link_act_led[0];
      end
      falls = 0;
      zeros = 0;
      for (int j = 0; j < 40; j++) begin
         if (!hist[j]) zeros++;
         if (j > 0 && hist[j-1] && !hist[j]) falls++;
      end
      check("blink_falls", falls, 32'd1);
      check($sformatf("blink_off_len=%0d", zeros), (zeros >= 5 && zeros <= 8), 32'd1);
      check("blink_settle", hist[39], 32'd1);

      // continuous traffic on port 1
      for (int j = 0; j < 4; j++) cycle(4'b0011, 4'b0000, 2'b00, 1'b0);
      for (int j = 0; j < 104; j++) begin
         cycle(4'b0011, (j < 64) ? 4'b0010 : 4'b0000, 2'b00, 1'b0);
         hist[j] = bus.link_act_led[1];
      end
      prev_t = -1;
      falls  = 0;
      runs   = 0;
      for (int j = 1; j < 104; j++) begin
         if (hist[j] != hist[j-1]) begin
            if (prev_t >= 0) begin
               len = j - prev_t;
               check($sformatf("traffic_half_len=%0d", len), (len >= 5 && len <= 8), 32'd1);
            end
            prev_t = j;
            runs++;
            if (!hist[j] && j >= 66) falls++;
         end
      end
      check($sformatf("traffic_toggles=%0d", runs), (runs >= 8), 32'd1);
      check($sformatf("traffic_late_falls=%0d", falls), (falls <= 1), 32'd1);
      check("traffic_settle", hist[103], 32'd1);

      // link loss in the middle of a blink on port 0
      cycle(4'b0001, 4'b0001, 2'b00, 1'b0);
      for (int j = 0; j < 3; j++) cycle(4'b0001, 4'b0000, 2'b00, 1'b0);
      check("loss_blink_off", bus.link_act_led[0], 32'd0);
      for (int j = 0; j < 5; j++) cycle(4'b0000, 4'b0001, 2'b00, 1'b0);
      check("loss_dark", bus.link_act_led[0], 32'd0);
      zeros = 0;
      for (int j = 0; j < 30; j++) begin
         cycle(4'b0001, 4'b0000, 2'b00, 1'b0);
         if (j >= 1 && !bus.link_act_led[0]) zeros++;
      end
      check("relink_steady_zeros", zeros, 32'd0);

      // event stretch, single pulse
      ones = 0;
      last = 0;
      for (int j = 0; j < 20; j++) begin
         cycle(4'b0001, 4'b0000, (j == 0) ? 2'b01 : 2'b00, 1'b0);
         if (bus.event_led[0]) begin
            ones++;
            last = j;
         end
      end
      check($sformatf("stretch_len=%0d", ones), (ones >= 9 && ones <= 12), 32'd1);
      check("stretch_contig", ones, last);

      // event retrigger 6 cycles after the first pulse
      ones = 0;
      last = 0;
      for (int j = 0; j < 26; j++) begin
         cycle(4'b0001, 4'b0000, (j == 0 || j == 6) ? 2'b01 : 2'b00, 1'b0);
         if (bus.event_led[0]) begin
            ones++;
            last = j;
         end
      end
      check($sformatf("retrig_len=%0d", last - 6), (last - 6 >= 9 && last - 6 <= 12), 32'd1);
      check("retrig_contig", ones, last);

      // lamp test walk
      for (int j = 0; j < 80; j++) begin
         cycle(4'b0001, 4'b0000, 2'b00, 1'b1);
         wsmp[j] = {bus.event_led, bus.link_act_led};
      end
      check("walk_first", wsmp[0], 32'h1);
      runs      = 0;
      run_start = 0;
      for (int j = 1; j < 80; j++) begin
         if (wsmp[j] != wsmp[j-1]) begin
            oh = '0;
            oh[runs % N] = 1'b1;
            len = j - run_start;
            check($sformatf("walk_val%0d", runs), wsmp[j-1], oh);
            check($sformatf("walk_len=%0d", len), (len >= 5 && len <= 8), 32'd1);
            runs++;
            run_start = j;
         end
      end
      check($sformatf("walk_runs=%0d", runs), (runs >= 7), 32'd1);
      cycle(4'b0001, 4'b0000, 2'b00, 1'b0);
      check("walk_exit", {bus.event_led, bus.link_act_led}, 32'h1);

      // reset in the middle of a walk, walk restarts at index 0
      for (int j = 0; j < 11; j++) cycle(4'b0001, 4'b0000, 2'b00, 1'b1);
      do_reset();
      cycle(4'b0001, 4'b0000, 2'b00, 1'b1);
      check("walk_restart", {bus.event_led, bus.link_act_led}, 32'h1);

      // randomized traffic, events, lamp test toggling, one mid-run reset
      lnk = 4'b1011;
      tm  = 1'b0;
      for (int i = 0; i < 900; i++) begin
         if ($urandom_range(0, 31) == 0) begin
            b = $urandom_range(0, P - 1);
            lnk[b] = ~lnk[b];
         end
         act = P'($urandom) & P'($urandom) & P'($urandom);
         ev  = E'($urandom) & E'($urandom) & E'($urandom) & E'($urandom);
         if ($urandom_range(0, 99) == 0) tm = ~tm;
         if (i == 450) do_reset();
         cycle(lnk, act, ev, tm);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
